// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Front end for the 64-point FFT core. It accepts complex 16-bit samples over a
// valid/ready handshake and writes each one into a frame buffer. When a complete
// frame has arrived (in_last on the final sample), it issues a one-cycle fft_start.
// It then holds the buffer stable until fft_done.
//
// Build option: define FFT_LOADER_BITREV_EN to store sample k at bitrev(k).
// Leave it undefined to store samples in natural order (index k).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    sample handshake
//   in_re, in_im         sample real/imag parts, two's complement
//   in_last              final sample of a frame
//   fft_start            one-cycle launch pulse to the FFT core
//   fft_done             FFT core has finished with the buffer
//   frame_re, frame_im   frame buffer contents, entry [i] at index i
//   busy                 frame handed to the FFT and not yet released
//   frame_err            one-cycle pulse: in_last mismatch, frame discarded
module fft_frame_loader #(
  parameter int unsigned D_WIDTH     = 64,
  parameter int unsigned LOG_2_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_re,
  input  logic [15:0]               in_im,
  input  logic                      in_last,
  output logic                      fft_start,
  input  logic                      fft_done,
  output logic [D_WIDTH-1:0][15:0]  frame_re,
  output logic [D_WIDTH-1:0][15:0]  frame_im,
  output logic                      busy,
  output logic                      frame_err
);

  localparam logic [LOG_2_WIDTH-1:0] KMax = LOG_2_WIDTH'(D_WIDTH - 1);

  typedef enum logic [1:0] {StLoad, StStart, StCompute} state_e;

  state_e                 state_q;
  logic [LOG_2_WIDTH-1:0] k_q;
  logic [LOG_2_WIDTH-1:0] widx;
  logic                   accept;
  logic                   k_is_last;

  // in_ready is a register, so no accept is possible in START or COMPUTE
  // or in the first cycle after reset release.
  assign accept    = in_valid && in_ready;
  assign k_is_last = (k_q == KMax);

  always_comb begin
    widx = k_q;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < int'(LOG_2_WIDTH); i++) begin
      widx[i] = k_q[LOG_2_WIDTH-1-i];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StLoad;
      k_q       <= '0;
      in_ready  <= 1'b0;
      fft_start <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      frame_re  <= '0;
      frame_im  <= '0;
    end else begin
      fft_start <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StLoad: begin
          in_ready <= 1'b1;
          if (accept) begin
            // The offending sample of a bad frame is written too.
            frame_re[widx] <= in_re;
            frame_im[widx] <= in_im;
            if (in_last && k_is_last) begin
              state_q   <= StStart;
              k_q       <= '0;
              in_ready  <= 1'b0;
              fft_start <= 1'b1;
              busy      <= 1'b1;
            end else if (in_last != k_is_last) begin
              frame_err <= 1'b1;
              k_q       <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        StStart: begin
          state_q <= StCompute;
        end
        StCompute: begin
          if (fft_done) begin
            state_q  <= StLoad;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

endmodule
